// File: rtl/png_enc_top.sv
// PNG encoder scanline datapath: filter-type word, per-lane Sub filter,
// registered LZ77 stage (pass-through), row counting and end-of-image pulse.

// One byte lane of the Sub filter: difference to the left neighbour, mod 256.
module png_sub_lane (
    input  logic [7:0] cur,
    input  logic [7:0] left,
    output logic [7:0] f
);
    assign f = cur - left;
endmodule

module png_enc_top #(
    parameter int SIZE_W_WD   = 12,
    parameter int SIZE_H_WD   = 12,
    parameter int DATA_PXL_WD = 32
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [SIZE_W_WD-1:0]   cfg_w_i,
    input  logic [SIZE_H_WD-1:0]   cfg_h_i,
    input  logic                   start_i,
    output logic                   done_o,
    input  logic                   val_i,
    input  logic [DATA_PXL_WD-1:0] dat_i,
    output logic                   val_o,
    output logic [DATA_PXL_WD-1:0] dat_o
);
    localparam int NUM_LANES = DATA_PXL_WD / 8;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state, state_nxt;
    logic [SIZE_W_WD-1:0]   cfg_w, px_cnt;
    logic [SIZE_H_WD-1:0]   cfg_h, row_cnt, row_nxt;
    logic [DATA_PXL_WD-1:0] left_px, sub_dat, s1_dat;
    logic                   s1_last, out_last;
    // [0] filtered-word stage, [1] LZ77 output stage (drives val_o)
    logic [1:0]             vld_pipe;
    logic                   lz77_done_o;
    logic                   start_acc, acc, acc_last, row_end;

    assign start_acc = (state == IDLE) && start_i;
    // Pixels beyond the configured width are dropped here
    assign acc       = (state == RUN) && val_i && (px_cnt != cfg_w);
    assign acc_last  = acc && (px_cnt == cfg_w - 1'b1);
    // Last word of the row currently on the output
    assign row_end   = vld_pipe[1] && out_last;
    assign row_nxt   = row_cnt + 1'b1;
    assign val_o     = vld_pipe[1];

    genvar b;
    generate
        for (b = 0; b < NUM_LANES; b++) begin : g_lane
            png_sub_lane u_lane (
                .cur  (dat_i[b*8 +: 8]),
                .left (left_px[b*8 +: 8]),
                .f    (sub_dat[b*8 +: 8])
            );
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state: a row runs from accepted start until its done pulse
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_i)     state_nxt = RUN;
            RUN:  if (lz77_done_o) state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    // Row configuration and pixel counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cfg_w  <= '0;
            cfg_h  <= '0;
            px_cnt <= '0;
        end else if (start_acc) begin
            cfg_w  <= cfg_w_i;
            cfg_h  <= cfg_h_i;
            px_cnt <= '0;
        end else if (acc) begin
            px_cnt <= px_cnt + 1'b1;
        end
    end

    // Stage 1: Sub-filtered word; left neighbour restarts at zero each row
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_pipe[0] <= 1'b0;
            s1_last     <= 1'b0;
            s1_dat      <= '0;
            left_px     <= '0;
        end else begin
            vld_pipe[0] <= acc;
            s1_last     <= acc_last;
            if (start_acc) left_px <= '0;
            else if (acc)  left_px <= dat_i;
            if (acc)       s1_dat  <= sub_dat;
        end
    end

    // LZ77 stage (pass-through register); filter-type word goes out right after start
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_pipe[1] <= 1'b0;
            dat_o       <= '0;
            out_last    <= 1'b0;
        end else begin
            vld_pipe[1] <= vld_pipe[0] || start_acc;
            if (start_acc) begin
                dat_o    <= DATA_PXL_WD'(1);
                out_last <= (cfg_w_i == '0);
            end else if (vld_pipe[0]) begin
                dat_o    <= s1_dat;
                out_last <= s1_last;
            end
        end
    end

    // Row end pulses and row counter; wraps to zero on the image's last row
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lz77_done_o <= 1'b0;
            done_o      <= 1'b0;
            row_cnt     <= '0;
        end else begin
            lz77_done_o <= row_end;
            done_o      <= row_end && (row_nxt == cfg_h);
            if (row_end) row_cnt <= (row_nxt == cfg_h) ? '0 : row_nxt;
        end
    end
endmodule

// File: tb/tb_png_enc_top.sv
// Directed bench for png_enc_top: reset, filter values, lane wrap, mid-row
// start / extra pixels, abort by reset, zero-width row, full 256x256 image.
module tb_png_enc_top;
    logic        clk = 1'b0;
    logic        rstn;
    logic [11:0] cfg_w_i, cfg_h_i;
    logic        start_i, done_o, val_i, val_o;
    logic [31:0] dat_i, dat_o;

    int          n_chk = 0, n_err = 0;
    int          cyc = 0, ld_cnt = 0, ld_cyc = 0, dn_cnt = 0, dn_cyc = 0;
    logic [31:0] words[$];
    logic [31:0] px[0:299];

    png_enc_top dut (
        .clk(clk), .rstn(rstn), .cfg_w_i(cfg_w_i), .cfg_h_i(cfg_h_i),
        .start_i(start_i), .done_o(done_o), .val_i(val_i), .dat_i(dat_i),
        .val_o(val_o), .dat_o(dat_o)
    );

    always #5 clk = ~clk;

    // Sample outputs 2 time units after each rising edge
    always @(posedge clk) begin
        cyc++;
        #2;
        if (val_o) words.push_back(dat_o);
        if (dut.lz77_done_o) begin ld_cnt++; ld_cyc = cyc; end
        if (done_o) begin dn_cnt++; dn_cyc = cyc; end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One row: start, npx back-to-back pixels from px[], optional start pulse
    // on the second pixel; waits (bounded) for the row-done pulse.
    task automatic do_row(input int w, input int h, input int npx, input bit mid_start,
                          output int lat);
        int ld0, t0;
        words.delete();
        ld0 = ld_cnt;
        @(negedge clk);
        cfg_w_i = 12'(w); cfg_h_i = 12'(h); start_i = 1'b1; t0 = cyc;
        for (int i = 0; i < npx; i++) begin
            @(negedge clk);
            start_i = mid_start && (i == 1);
            val_i = 1'b1; dat_i = px[i];
        end
        @(negedge clk);
        start_i = 1'b0; val_i = 1'b0; dat_i = 32'hDEAD_BEEF;
        for (int k = 0; k < 600 && ld_cnt == ld0; k++) @(negedge clk);
        if (ld_cnt == ld0) begin
            chk("row_timeout", 32'(ld_cnt), 32'(ld0 + 1));
            lat = -1;
        end else begin
            lat = ld_cyc - t0;
        end
    endtask

    initial begin
        int lat, bad, dn0;
        rstn = 1'b0; start_i = 1'b0; val_i = 1'b0; dat_i = '0;
        cfg_w_i = '0; cfg_h_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_val", 32'(val_o), 0);
        chk("rst_dat", dat_o, 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_lz", 32'(dut.lz77_done_o), 0);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_val", 32'(val_o), 0);
        chk("idle_lz", 32'(ld_cnt), 0);

        // w=3, h=1
        px[0] = 32'h0102_0304; px[1] = 32'h0102_0305; px[2] = 32'h0000_0000;
        dn0 = dn_cnt;
        do_row(3, 1, 3, 1'b0, lat);
        chk("r1_cnt", 32'(words.size()), 4);
        if (words.size() == 4) begin
            chk("r1_w0", words[0], 32'h0000_0001);
            chk("r1_w1", words[1], 32'h0102_0304);
            chk("r1_w2", words[2], 32'h0000_0001);
            chk("r1_w3", words[3], 32'hFFFE_FDFB);
        end
        chk("r1_lat", 32'(lat), 6);
        chk("r1_done", 32'(dn_cnt - dn0), 1);
        chk("r1_same", 32'(dn_cyc), 32'(ld_cyc));

        // Byte-lane underflow and lane independence
        px[0] = 32'h0000_0000; px[1] = 32'h0101_0101; px[2] = 32'h0000_0000;
        px[3] = 32'h80FF_0001; px[4] = 32'h7F00_FF02;
        do_row(5, 1, 5, 1'b0, lat);
        chk("wr_cnt", 32'(words.size()), 6);
        if (words.size() == 6) begin
            chk("wr_w1", words[1], 32'h0000_0000);
            chk("wr_w2", words[2], 32'h0101_0101);
            chk("wr_w3", words[3], 32'hFFFF_FFFF);
            chk("wr_w4", words[4], 32'h80FF_0001);
            chk("wr_w5", words[5], 32'hFF01_FF01);
        end

        // Mid-row start and extra pixels ignored; h=2 so no done yet
        px[0] = 32'h1122_3344; px[1] = 32'h2233_4455; px[2] = 32'h9999_9999; px[3] = 32'h7777_7777;
        dn0 = dn_cnt;
        do_row(2, 2, 4, 1'b1, lat);
        chk("ms_cnt", 32'(words.size()), 3);
        if (words.size() == 3) begin
            chk("ms_w1", words[1], 32'h1122_3344);
            chk("ms_w2", words[2], 32'h1111_1111);
        end
        chk("ms_nodone", 32'(dn_cnt - dn0), 0);
        chk("ms_row", 32'(dut.row_cnt), 1);

        // Reset mid-row aborts everything, including the pending row count
        @(negedge clk);
        cfg_w_i = 12'd4; cfg_h_i = 12'd2; start_i = 1'b1;
        @(negedge clk); start_i = 1'b0; val_i = 1'b1; dat_i = 32'h5555_5555;
        @(negedge clk); dat_i = 32'h6666_6666;
        @(negedge clk); val_i = 1'b0;
        rstn = 1'b0;
        #1;
        chk("ab_val", 32'(val_o), 0);
        chk("ab_dat", dat_o, 0);
        chk("ab_row", 32'(dut.row_cnt), 0);
        @(negedge clk); rstn = 1'b1;
        px[0] = 32'h0A0B_0C0D; px[1] = 32'h0A0B_0C0E;
        dn0 = dn_cnt;
        do_row(2, 2, 2, 1'b0, lat);
        chk("ab_cnt", 32'(words.size()), 3);
        if (words.size() == 3) begin
            chk("ab_w1", words[1], 32'h0A0B_0C0D);
            chk("ab_w2", words[2], 32'h0000_0001);
        end
        chk("ab_nodone", 32'(dn_cnt - dn0), 0);
        chk("ab_row1", 32'(dut.row_cnt), 1);

        // Zero-width row closes the h=2 image
        do_row(0, 2, 0, 1'b0, lat);
        chk("w0_cnt", 32'(words.size()), 1);
        chk("w0_lat", 32'(lat), 2);
        chk("w0_done", 32'(dn_cnt - dn0), 1);
        chk("w0_row", 32'(dut.row_cnt), 0);

        // 256x256 image, pixels ramp by 01010101
        for (int i = 0; i < 256; i++) px[i] = 32'(i) * 32'h0101_0101;
        bad = 0;
        dn0 = dn_cnt;
        for (int r = 0; r < 256; r++) begin
            do_row(256, 256, 256, 1'b0, lat);
            if (lat != 259) bad++;
            if (r == 254) chk("img_nodone", 32'(dn_cnt - dn0), 0);
        end
        chk("img_lat", 32'(bad), 0);
        chk("img_done", 32'(dn_cnt - dn0), 1);
        chk("img_row", 32'(dut.row_cnt), 0);
        chk("img_cnt", 32'(words.size()), 257);
        if (words.size() == 257) chk("img_last", words[256], 32'h0101_0101);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
